// File: rtl/req_arbiter_4.sv
// Round-robin arbiter for four requesters with a per-grant hold limit.
// A decoder on the granted index drives the one-hot grant, and a mux on the same index steers that requester's data out.
module req_arbiter_4 #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 15
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [3:0]            i_req,
   input  logic [3:0]            i_done,
   input  logic [4*DATA_W-1:0]   i_data_in,
   output logic [3:0]            o_grant,
   output logic [1:0]            o_gnt_idx,
   output logic                  o_gnt_valid,
   output logic [DATA_W-1:0]     o_data_out,
   output logic                  o_timeout
);
   localparam int NUM_LANES = 4;
   localparam int CNT_W     = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                           r_state;
   logic [1:0]                       r_ptr;
   logic [1:0]                       r_gnt_idx;
   logic [CNT_W-1:0]                 r_cnt;
   logic                             r_timeout;

   logic [1:0]                       w_pick;
   logic                             w_user_rel;
   logic                             w_limit;
   logic [NUM_LANES-1:0][DATA_W-1:0] w_words;

   assign w_words = i_data_in;

   // Scan downward from ptr+3, so the requester closest to ptr is the last to overwrite w_pick.
   always_comb begin
      w_pick = r_ptr;
      for (int k = NUM_LANES - 1; k >= 0; k--)
         if (i_req[r_ptr + 2'(k)]) w_pick = r_ptr + 2'(k);
   end

   assign w_user_rel = i_done[r_gnt_idx] | ~i_req[r_gnt_idx];
   assign w_limit    = (r_cnt == HOLD_LAST);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_ptr     <= 2'd0;
         r_gnt_idx <= 2'd0;
         r_cnt     <= '0;
         r_timeout <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_timeout <= 1'b0;
               if (|i_req) begin
                  r_gnt_idx <= w_pick;
                  r_cnt     <= '0;
                  r_state   <= BUSY;
               end
            end
            BUSY: begin
               if (w_user_rel || w_limit) begin
                  r_state   <= IDLE;
                  r_ptr     <= r_gnt_idx + 2'd1;
                  // A release by the owner wins over the limit on the same edge.
                  r_timeout <= ~w_user_rel;
               end else begin
                  r_cnt     <= r_cnt + CNT_W'(1);
                  r_timeout <= 1'b0;
               end
            end
         endcase
      end
   end

   assign o_gnt_valid = (r_state == BUSY);
   assign o_gnt_idx   = r_gnt_idx;
   assign o_timeout   = r_timeout;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_dec
      assign o_grant[g] = o_gnt_valid && (r_gnt_idx == 2'(g));
   end

   assign o_data_out = o_gnt_valid ? w_words[r_gnt_idx] : '0;

endmodule

// File: tb/tb_req_arbiter_4.sv
// Bench for req_arbiter_4: directed scenarios checked against fixed expectations.
// A random phase is checked against an ownership model that mirrors the arbiter's behaviour at the level of owner, hold count and next start position.
module tb_req_arbiter_4;
   localparam int DATA_W   = 8;
   localparam int MAX_HOLD = 15;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [3:0]          req = '0;
   logic [3:0]          done = '0;
   logic [4*DATA_W-1:0] data_in = '0;
   logic [3:0]          grant;
   logic [1:0]          gnt_idx;
   logic                gnt_valid;
   logic [DATA_W-1:0]   data_out;
   logic                timeout;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   req_arbiter_4 #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_done(done), .i_data_in(data_in),
      .o_grant(grant), .o_gnt_idx(gnt_idx), .o_gnt_valid(gnt_valid),
      .o_data_out(data_out), .o_timeout(timeout)
   );

   // Reference: who owns the channel, for how many cycles so far, where the next scan starts.
   int owner = -1;
   int held = 0;
   int rr = 0;
   int last = 0;
   bit m_to = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         owner = -1; held = 0; rr = 0; last = 0; m_to = 1'b0;
      end else if (owner < 0) begin
         m_to = 1'b0;
         for (int k = 0; k < 4; k++)
            if (owner < 0 && req[(rr + k) % 4]) owner = (rr + k) % 4;
         if (owner >= 0) begin
            held = 1;
            last = owner;
         end
      end else begin
         if (done[owner] || !req[owner] || held == MAX_HOLD) begin
            m_to  = !(done[owner] || !req[owner]);
            rr    = (owner + 1) % 4;
            owner = -1;
         end else begin
            held++;
            m_to = 1'b0;
         end
      end
   end

   function automatic logic [3:0] exp_grant();
      return (owner < 0) ? 4'b0000 : 4'(1 << owner);
   endfunction

   function automatic logic [DATA_W-1:0] exp_data();
      return (owner < 0) ? '0 : data_in[owner*DATA_W +: DATA_W];
   endfunction

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_out();
      req = '0; done = '0;
      cyc(); cyc();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req = 4'b1111; data_in = 32'h44332211;
      cyc(); cyc();
      n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got %b want 0000", grant); end
      n_chk++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_out); end
      n_chk++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b want 0", timeout); end
      n_chk++; if (gnt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", gnt_valid); end
      rst_n = 1'b1;
      cyc();
      n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant got %b want 0001", grant); end
      n_chk++; if (gnt_idx !== 2'd0) begin n_fail++; $display("FAIL reset_first_idx got %0d want 0", gnt_idx); end
      n_chk++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL reset_first_data got %h want 11", data_out); end
      done = 4'b0001;
      cyc();
      n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_release got %b want 0000", grant); end
      idle_out();
   endtask

   task automatic test_single();
      req = 4'b0100; data_in = 32'h00A50000;
      cyc();
      n_chk++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant got %b want 0100", grant); end
      n_chk++; if (gnt_idx !== 2'd2) begin n_fail++; $display("FAIL single_idx got %0d want 2", gnt_idx); end
      n_chk++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL single_data got %h want a5", data_out); end
      data_in = 32'h553C7788;
      #1;
      n_chk++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL single_comb_data got %h want 3c", data_out); end
      done = 4'b0100;
      cyc();
      n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_release got %b want 0000", grant); end
      n_chk++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL single_idle_data got %h want 00", data_out); end
      n_chk++; if (gnt_idx !== 2'd2) begin n_fail++; $display("FAIL single_idx_hold got %0d want 2", gnt_idx); end
      idle_out();
   endtask

   task automatic test_round_robin();
      logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_chk++; if (grant !== seq[i]) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", i, grant, seq[i]); end
         done = seq[i];
         cyc();
         n_chk++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rr_gap[%0d] got %b want 0000", i, grant); end
         done = '0;
      end
      idle_out();
   endtask

   task automatic test_timeout();
      req = 4'b0001;
      for (int c = 0; c < MAX_HOLD; c++) begin
         cyc();
         n_chk++; if (grant !== 4'b0001 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL to_hold[%0d] got grant %b timeout %b want 0001/0", c, grant, timeout);
         end
      end
      cyc();
      n_chk++; if (grant !== 4'b0000 || timeout !== 1'b1) begin
         n_fail++; $display("FAIL to_release got grant %b timeout %b want 0000/1", grant, timeout);
      end
      cyc();
      n_chk++; if (grant !== 4'b0001 || timeout !== 1'b0) begin
         n_fail++; $display("FAIL to_regrant got grant %b timeout %b want 0001/0", grant, timeout);
      end
      for (int c = 1; c < MAX_HOLD; c++) cyc();
      done = 4'b0001;
      cyc();
      n_chk++; if (grant !== 4'b0000 || timeout !== 1'b0) begin
         n_fail++; $display("FAIL to_done_wins got grant %b timeout %b want 0000/0", grant, timeout);
      end
      idle_out();
   endtask

   task automatic test_wrap();
      req = 4'b1000;
      cyc();
      n_chk++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL wrap_g3 got %b want 1000", grant); end
      done = 4'b1000; cyc();
      req = 4'b1001; done = '0;
      cyc();
      n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL wrap_1001 got %b want 0001", grant); end
      done = 4'b0001; req = '0; cyc();
      req = 4'b0010; done = '0;
      cyc();
      n_chk++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL wrap_g1 got %b want 0010", grant); end
      done = 4'b0010; cyc();
      req = 4'b0011; done = '0;
      cyc();
      n_chk++; if (grant !== 4'b0001) begin n_fail++; $display("FAIL wrap_0011 got %b want 0001", grant); end
      idle_out();
   endtask

   task automatic test_reset_mid();
      req = 4'b0100; data_in = 32'hDEADBEEF;
      cyc();
      n_chk++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL mid_pre got %b want 0100", grant); end
      rst_n = 1'b0;
      cyc();
      n_chk++; if (grant !== 4'b0000 || gnt_valid !== 1'b0 || gnt_idx !== 2'd0 || data_out !== 8'h00 || timeout !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset got %b/%b/%0d/%h/%b want 0000/0/0/00/0", grant, gnt_valid, gnt_idx, data_out, timeout);
      end
      rst_n = 1'b1; req = 4'b0110;
      cyc();
      n_chk++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL mid_after got %b want 0010", grant); end
      idle_out();
   endtask

   task automatic test_random();
      int n_to = 0;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         n_chk++; if (grant !== exp_grant()) begin n_fail++; $display("FAIL rnd_grant@%0d got %b want %b", c, grant, exp_grant()); end
         n_chk++; if (gnt_valid !== (owner >= 0)) begin n_fail++; $display("FAIL rnd_valid@%0d got %b want %b", c, gnt_valid, owner >= 0); end
         n_chk++; if (gnt_idx !== 2'(last)) begin n_fail++; $display("FAIL rnd_idx@%0d got %0d want %0d", c, gnt_idx, last); end
         n_chk++; if (data_out !== exp_data()) begin n_fail++; $display("FAIL rnd_data@%0d got %h want %h", c, data_out, exp_data()); end
         n_chk++; if (timeout !== m_to) begin n_fail++; $display("FAIL rnd_timeout@%0d got %b want %b", c, timeout, m_to); end
         if (m_to) n_to++;
         for (int b = 0; b < 4; b++) begin
            if ($urandom_range(15) == 0) req[b] = ~req[b];
            done[b] = ($urandom_range(19) == 0);
         end
         data_in = {$urandom, $urandom} >> $urandom_range(31);
         rst_n = ($urandom_range(199) != 0);
      end
      rst_n = 1'b1;
      if (n_to == 0) $display("note: random phase produced no timeouts");
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
